// File: rtl/md_iter_unit_if.sv
// ---------------------------------------------------------------------------
// md_iter_unit_if
//   Request/response bundle between the pipeline and the iterative
//   multiply/divide unit (md_iter_unit).
//
//   master (pipeline side) drives:
//     start    launch an operation (taken only while busy=0)
//     op       00 mult, 01 multu, 10 div, 11 divu
//     a, b     rs / rt operands
//     wr_hi    mthi strobe
//     wr_lo    mtlo strobe
//     wdata    mthi/mtlo data
//     abort    pipeline flush (only with MD_ABORT_EN defined)
//   slave (unit side) drives:
//     busy     operation in flight
//     done     one-cycle pulse, hi/lo hold the new result
//     div0     qualifies done: the finished op was a divide by zero
//     hi, lo   architectural HI/LO registers
//
//   Optional feature macro: MD_ABORT_EN adds the abort signal.
// ---------------------------------------------------------------------------
interface md_iter_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            wr_hi;
   logic            wr_lo;
   logic [XLEN-1:0] wdata;
`ifdef MD_ABORT_EN
   logic            abort;
`endif
   logic            busy;
   logic            done;
   logic            div0;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
`ifdef MD_ABORT_EN
      output abort,
`endif
      output start, op, a, b, wr_hi, wr_lo, wdata,
      input  busy, done, div0, hi, lo
   );

   modport slave (
`ifdef MD_ABORT_EN
      input  abort,
`endif
      input  start, op, a, b, wr_hi, wr_lo, wdata,
      output busy, done, div0, hi, lo
   );
endinterface

// File: rtl/md_iter_unit.sv
// ---------------------------------------------------------------------------
// md_iter_unit
//   Iterative radix-2 multiply/divide unit with the HI/LO register pair.
//   One bit per cycle: IDLE -> CALC (XLEN cycles) -> FIX (1 cycle) -> IDLE.
//   Latency from accepted start to done is XLEN+2 cycles; a divide by zero
//   skips CALC and completes in 2 cycles.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-low reset
//     bus   md_iter_unit_if.slave (start/op/a/b, mthi/mtlo, busy/done/div0,
//           hi/lo)
//
//   Optional feature macro: MD_ABORT_EN. When defined, bus.abort cancels an
//   in-flight op (HI/LO untouched, no done) and blocks a start in IDLE.
//   When undefined, every accepted op runs to completion.
// ---------------------------------------------------------------------------
module md_iter_unit #(
   parameter int XLEN = 32
) (
   input logic         clk,
   input logic         rst,
   md_iter_unit_if.slave bus
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   // Shared accumulator. Multiply: {partial upper, remaining multiplier}.
   // Divide: {partial remainder, dividend bits shifting into quotient}.
   logic [2*XLEN-1:0] acc;
   // Multiplicand magnitude (mult) or divisor magnitude (div).
   logic [XLEN-1:0]   opnd;
   logic              is_div;
   logic              is_dz;
   logic              sign_a;
   logic              sign_b;
   logic [XLEN-1:0]   hi_q;
   logic [XLEN-1:0]   lo_q;
   logic              done_q;
   logic              div0_q;

   logic              abort_req;
`ifdef MD_ABORT_EN
   assign abort_req = bus.abort;
`else
   assign abort_req = 1'b0;
`endif

   logic              neg_a;
   logic              neg_b;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] mul_next;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;

   // NOTE: every signal in this block is assigned on every path through it,
   // so no latch can be inferred; keep it that way when adding branches.
   always_comb begin
      // Unsigned ops (op[0]=1) force both sign flags to 0.
      neg_a = ~bus.op[0] & bus.a[XLEN-1];
      neg_b = ~bus.op[0] & bus.b[XLEN-1];
      // -MIN wraps back to MIN, which is the correct unsigned magnitude.
      mag_a = neg_a ? -bus.a : bus.a;
      mag_b = neg_b ? -bus.b : bus.b;

      // Shift-add step: add multiplicand on multiplier LSB, shift right.
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};

      // Restoring step: shift in next dividend bit, subtract if it fits.
      rem_sh   = acc[2*XLEN-1:XLEN-1];
      diff     = rem_sh - {1'b0, opnd};
      div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};

      // Sign correction applied in FIX.
      prod_fix = (sign_a ^ sign_b) ? -acc : acc;
      quo_fix  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
   end

   // NOTE: all state, including the FSM and its registered outputs, is updated
   // with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         is_dz  <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         div0_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start && !abort_req) begin
                  div0_q <= 1'b0;
                  is_div <= bus.op[1];
                  sign_a <= neg_a;
                  sign_b <= neg_b;
                  if (bus.op[1] && (bus.b == '0)) begin
                     // Divide by zero: keep the raw dividend for HI.
                     is_dz <= 1'b1;
                     acc   <= {{XLEN{1'b0}}, bus.a};
                     opnd  <= '0;
                     state <= S_FIX;
                  end else begin
                     is_dz <= 1'b0;
                     acc   <= bus.op[1] ? {{XLEN{1'b0}}, mag_a}
                                        : {{XLEN{1'b0}}, mag_b};
                     opnd  <= bus.op[1] ? mag_b : mag_a;
                     cnt   <= CW'(XLEN - 1);
                     state <= S_CALC;
                  end
               end else if (!bus.start) begin
                  // mthi/mtlo only land in a quiet idle cycle; start wins.
                  if (bus.wr_hi) hi_q <= bus.wdata;
                  if (bus.wr_lo) lo_q <= bus.wdata;
               end
            end

            S_CALC: begin
               if (abort_req) begin
                  state  <= S_IDLE;
                  div0_q <= 1'b0;
               end else begin
                  acc <= is_div ? div_next : mul_next;
                  if (cnt == '0) state <= S_FIX;
                  else           cnt   <= cnt - 1'b1;
               end
            end

            S_FIX: begin
               state <= S_IDLE;
               if (abort_req) begin
                  div0_q <= 1'b0;
               end else begin
                  done_q <= 1'b1;
                  div0_q <= is_dz;
                  if (is_dz) begin
                     lo_q <= '1;
                     hi_q <= acc[XLEN-1:0];
                  end else if (is_div) begin
                     lo_q <= quo_fix;
                     hi_q <= rem_fix;
                  end else begin
                     hi_q <= prod_fix[2*XLEN-1:XLEN];
                     lo_q <= prod_fix[XLEN-1:0];
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = (state != S_IDLE);
   assign bus.done = done_q;
   assign bus.div0 = div0_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule
